avalon_word_mem: RTL and testbench

- Word-organised on-chip memory with an Avalon-MM slave interface, pipelined variable-latency reads and waitrequest backpressure.
- Sits directly downstream of the word-copy accelerator's master port.
- Services the accelerator's source reads and destination writes, so the copy engine can be exercised against realistic readdatavalid timing.

---
 rtl/avalon_word_mem.sv | 164 ++++++++++++++++
 tb/tb_avalon_word_mem.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_word_mem.sv
// -----------------------------------------------------------------------------
// avalon_word_mem
//   Word-organised on-chip memory behind an Avalon-MM slave port. Reads are
//   pipelined with a fixed READ_LATENCY, and up to MAX_PEND reads may be
//   outstanding. Backpressure is given through waitrequest.
//
// Parameters
//   AW           word-address width, depth = 2**AW 32-bit words
//   READ_LATENCY accept edge to the edge that samples readdatavalid (1..4)
//   MAX_PEND     accepted-but-unreturned reads allowed (1..READ_LATENCY)
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   address         byte address, word index = address[AW+1:2]
//   read, write     request strobes
//   writedata       write data
//   byteenable      per-byte write lane enables
//   waitrequest     request not accepted this cycle
//   readdata        read data, meaningful while readdatavalid=1, else held
//   readdatavalid   readdata valid this cycle
//   addr_err        sticky: misaligned or out-of-range access accepted
//   proto_err       sticky: read and write asserted together
//
// Optional build macro
//   AVMEM_STALL_INJECT_EN  adds LFSR-driven pseudo-random waitrequest stalls
// -----------------------------------------------------------------------------
module avalon_word_mem #(
    parameter int AW           = 10,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PEND     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        addr_err,
    output logic        proto_err
);

    localparam int         DEPTH      = 1 << AW;
    localparam logic [2:0] MAX_PEND_C = 3'(MAX_PEND);

    logic [31:0]             mem_r [DEPTH];
    logic [AW-1:0]           word_idx_s;
    logic                    out_of_range_s;
    logic                    misaligned_s;
    logic                    accept_s;
    logic                    rd_acc_s;
    logic                    wr_acc_s;
    logic                    stall_s;
    logic [31:0]             rd_word_s;
    logic [2:0]              pend_cnt_r;
    logic [READ_LATENCY-1:0] vld_pipe_r;
    logic [31:0]             dat_pipe_r [READ_LATENCY];

`ifdef AVMEM_STALL_INJECT_EN
    logic [7:0] lfsr_r;

    // Fibonacci step for x^8+x^6+x^5+x^4+1
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Stall-pattern LFSR, free-running outside reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end
`endif

    // Address decode, handshake and memory read port
    always_comb begin
        word_idx_s     = address[AW+1:2];
        out_of_range_s = (address >> (AW + 2)) != 32'd0;
        misaligned_s   = address[1:0] != 2'b00;
`ifdef AVMEM_STALL_INJECT_EN
        stall_s        = lfsr_r[1:0] == 2'b00;
`else
        stall_s        = 1'b0;
`endif
        // Only registered state feeds waitrequest; a read retiring this cycle
        // does not free its slot until the next edge.
        waitrequest    = rst | (pend_cnt_r == MAX_PEND_C) | stall_s;
        accept_s       = (read | write) & ~waitrequest;
        wr_acc_s       = accept_s & write;
        // read together with write is treated as a write only
        rd_acc_s       = accept_s & read & ~write;
        if (out_of_range_s) begin
            rd_word_s = 32'hDEADBEEF;
        end else begin
            rd_word_s = mem_r[word_idx_s];
        end
    end

    // Byte-lane writes; storage is deliberately untouched by reset
    always_ff @(posedge clk) begin
        if (wr_acc_s && !out_of_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Read response pipeline; data stages only load behind a valid so the
    // last stage holds the most recent response between returns
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_r <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_pipe_r[i] <= 32'd0;
            end
        end else begin
            vld_pipe_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                dat_pipe_r[0] <= rd_word_s;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                if (vld_pipe_r[i-1]) begin
                    dat_pipe_r[i] <= dat_pipe_r[i-1];
                end
            end
        end
    end

    assign readdatavalid = vld_pipe_r[READ_LATENCY-1];
    assign readdata      = dat_pipe_r[READ_LATENCY-1];

    // Outstanding read counter: +1 on read accept, -1 on each return
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_cnt_r <= 3'd0;
        end else begin
            pend_cnt_r <= pend_cnt_r + {2'b00, rd_acc_s} - {2'b00, readdatavalid};
        end
    end

    // Sticky error flags, raised only by accepted requests
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (accept_s && (out_of_range_s || misaligned_s)) begin
                addr_err <= 1'b1;
            end
            if (accept_s && read && write) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_word_mem.sv
// -----------------------------------------------------------------------------
// tb_avalon_word_mem
//   Table-driven bench with a read-response scoreboard for avalon_word_mem.
//   Expected read data and the cycle it must return in are queued when a read
//   is accepted; a negedge monitor pops and compares every readdatavalid.
//   A second instance (MAX_PEND=1, READ_LATENCY=3) checks backpressure timing.
//   Honours AVMEM_STALL_INJECT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_avalon_word_mem;

    localparam int AW  = 10;
    localparam int RL  = 2;
    localparam int MP  = 2;
    localparam int RL1 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest, readdatavalid, addr_err, proto_err;
    logic [3:0]  byteenable;

    logic [31:0] m_address, m_writedata, m_readdata;
    logic        m_read, m_write, m_wait, m_rdv, m_addr_err, m_proto_err;
    logic [3:0]  m_byteenable;

    always #5 clk = ~clk;

    avalon_word_mem #(.AW(AW), .READ_LATENCY(RL), .MAX_PEND(MP)) dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .addr_err(addr_err), .proto_err(proto_err)
    );

    avalon_word_mem #(.AW(AW), .READ_LATENCY(RL1), .MAX_PEND(1)) u_mp1 (
        .clk(clk), .rst(rst), .address(m_address), .read(m_read), .write(m_write),
        .writedata(m_writedata), .byteenable(m_byteenable), .waitrequest(m_wait),
        .readdata(m_readdata), .readdatavalid(m_rdv),
        .addr_err(m_addr_err), .proto_err(m_proto_err)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
    } vec_t;

    int          n_vec   = 0;
    int          n_miss  = 0;
    int          cyc     = 0;
    bit          started = 1'b0;
    exp_t        sb[$];
    logic [31:0] last_data = 32'd0;
    vec_t        vecs[15];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Response monitor: every readdatavalid must match the queue head in data
    // and arrival cycle; otherwise readdata must hold its last value.
    always @(negedge clk) begin
        if (started) begin
            if (readdatavalid === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_rdv: got data %h with nothing outstanding (cycle %0d)", readdata, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (readdata !== e.data || cyc != e.due) begin
                        n_miss++;
                        $display("FAIL read_resp: got %h at cycle %0d expected %h at cycle %0d",
                                 readdata, cyc, e.data, e.due);
                    end
                    last_data = e.data;
                end
            end else begin
                check("rdata_hold", readdata, last_data);
            end
            if (rst === 1'b1) begin
                sb.delete();
                last_data = 32'd0;
            end
        end
    end

    // Present a request at posedge+1 and hold it until accepted
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_data);
        bit done   = 1'b0;
        int budget = 0;
        read = rd; write = wr; address = a; writedata = wd; byteenable = be;
        while (!done) begin
            @(negedge clk);
            if (waitrequest === 1'b0) begin
                if (rd && !wr) sb.push_back('{exp_data, cyc + RL});
                done = 1'b1;
            end else if (budget > 50) begin
                n_vec++;
                n_miss++;
                $display("FAIL accept_timeout: waitrequest %b still high for address %h", waitrequest, a);
                done = 1'b1;
            end
            budget++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        read = 1'b0;
        write = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int b = 0;
        while (sb.size() != 0 && b < 100) begin
            @(posedge clk);
            b++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: got %0d responses outstanding expected 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    initial begin
        int acc, outst, last_acc, stalls, budget;

        rst = 1'b1; read = 1'b0; write = 1'b0; address = 32'd0; writedata = 32'd0; byteenable = 4'h0;
        m_read = 1'b0; m_write = 1'b0; m_address = 32'd0; m_writedata = 32'd0; m_byteenable = 4'h0;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_013C, 32'h0000_0025, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0140, 32'h0000_0026, 4'hF, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0144, 32'h0000_0027, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_013C, 32'h0,         4'hF, 32'h0000_0025};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0140, 32'h0,         4'hF, 32'h0000_0026};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0144, 32'h0,         4'hF, 32'h0000_0027};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_00AA, 4'h1, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         4'hF, 32'hFFFF_FFAA};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_0204, 32'hA1B2_C3D4, 4'hF, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0204, 32'h5566_7788, 4'hA, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         4'hF, 32'h55B2_77D4};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_013C, 32'h0,         4'hF, 32'h0000_0025};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_013C, 32'h0000_0099, 4'hF, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_013C, 32'h0,         4'hF, 32'h0000_0099};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wait_during_rst", {31'd0, waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        @(negedge clk);
        check("rst_rdv", {31'd0, readdatavalid}, 32'd0);
        check("rst_rdata", readdata, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_wait", {31'd0, waitrequest}, 32'd0);
        @(posedge clk);
        #1;

        // Table: back-to-back writes and reads, byte lanes, read-before-write
        for (int i = 0; i < 15; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_data);
        end
        idle(1);
        drain();
        @(negedge clk);
        check("clean_addr_err", {31'd0, addr_err}, 32'd0);
        check("clean_proto_err", {31'd0, proto_err}, 32'd0);
        @(posedge clk);
        #1;

        // Misaligned read uses the word index
        do_req(1'b1, 1'b0, 32'h0000_0142, 32'h0, 4'hF, 32'h0000_0026);
        idle(1);
        @(negedge clk);
        check("misalign_addr_err", {31'd0, addr_err}, 32'd1);
        check("misalign_proto_err", {31'd0, proto_err}, 32'd0);
        @(posedge clk);
        #1;

        // Out-of-range read/write, then read+write collision
        do_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hDEAD_BEEF);
        do_req(1'b0, 1'b1, 32'h0000_113C, 32'h0000_0077, 4'hF, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_013C, 32'h0, 4'hF, 32'h0000_0099);
        do_req(1'b1, 1'b1, 32'h0000_0148, 32'h0BAD_F00D, 4'hF, 32'h0);
        do_req(1'b1, 1'b0, 32'h0000_0148, 32'h0, 4'hF, 32'h0BAD_F00D);
        idle(1);
        drain();
        @(negedge clk);
        check("err_addr_err", {31'd0, addr_err}, 32'd1);
        check("err_proto_err", {31'd0, proto_err}, 32'd1);
        @(posedge clk);
        #1;

        // Reset with reads in flight: responses discarded, memory kept
        do_req(1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'hF, 32'h0000_0026);
        do_req(1'b1, 1'b0, 32'h0000_0144, 32'h0, 4'hF, 32'h0000_0027);
        read = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("wait_mid_rst", {31'd0, waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdv", {31'd0, readdatavalid}, 32'd0);
        check("post_rst_rdata", readdata, 32'd0);
        check("post_rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("post_rst_proto_err", {31'd0, proto_err}, 32'd0);
`ifndef AVMEM_STALL_INJECT_EN
        check("post_rst_wait", {31'd0, waitrequest}, 32'd0);
`endif
        @(posedge clk);
        #1;
        idle(4);
        do_req(1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'hF, 32'h0000_0026);
        do_req(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'hF, 32'h55B2_77D4);
        idle(1);
        drain();

        // MAX_PEND=1: a retiring read still holds waitrequest for its own
        // cycle, so accepts are READ_LATENCY+1 cycles apart
        acc = 0; outst = 0; last_acc = -1; stalls = 0; budget = 0;
        m_read = 1'b1;
        m_address = 32'h0000_0010;
        while (acc < 12 && budget < 300) begin
            @(negedge clk);
            budget++;
`ifdef AVMEM_STALL_INJECT_EN
            if (outst != 0) check("mp1_wait", {31'd0, m_wait}, 32'd1);
`else
            check("mp1_wait", {31'd0, m_wait}, {31'd0, outst != 0});
`endif
            if (outst == 0 && m_wait === 1'b1) stalls++;
            if (m_wait === 1'b0) begin
                if (last_acc >= 0) begin
`ifdef AVMEM_STALL_INJECT_EN
                    n_vec++;
                    if (cyc - last_acc < RL1 + 1) begin
                        n_miss++;
                        $display("FAIL mp1_spacing: got %0d expected at least %0d", cyc - last_acc, RL1 + 1);
                    end
`else
                    check("mp1_spacing", cyc - last_acc, RL1 + 1);
`endif
                end
                last_acc = cyc;
                acc++;
                outst++;
            end
            if (m_rdv === 1'b1) outst--;
            n_vec++;
            if (outst < 0 || outst > 1) begin
                n_miss++;
                $display("FAIL mp1_pending: got %0d outstanding expected 0 or 1", outst);
            end
        end
        m_read = 1'b0;
        check("mp1_accepts", acc, 32'd12);
`ifdef AVMEM_STALL_INJECT_EN
        check("stall_seen", {31'd0, stalls > 0}, 32'd1);
`endif
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
